// File: rtl/nios_system_nios2_mul_seq.sv
// ---------------------------------------------------------------------------
// nios_system_nios2_mul_seq
//
// Multi-cycle multiply sequencer that sits in front of the Nios II 32x32
// multiplier cell. The cell returns only the low 32 bits of its product, so:
//   - MUL (low word) is one pass with the full operands.
//   - MULXUU/MULXSU/MULXSS are four zero-extended 16x16 passes. Their
//     products are accumulated into a 64-bit unsigned product. The upper
//     word is then sign-corrected in one extra cycle.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   flush            synchronous kill of the in-flight op
//   req_valid/ready  request handshake; req_op/req_a/req_b latched on accept
//   rsp_valid/ready  response handshake; rsp_result held until rsp_ready
//   mc_src1/2        operands to the multiplier cell (0 when not in a pass)
//   mc_result        low 32 bits of the cell product
//   busy             high whenever the sequencer is not idle
//
// MC_LATENCY: clock edges from an mc_src change to a valid mc_result (1..3).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request, cell operands parked at 0
// PASS    | driving one pass's operands, waiting MC_LATENCY edges to capture
// CORR    | signed correction of the upper accumulator word
// RESP    | holding the result until rsp_ready
// ---------------------------------------------------------------------------
module nios_system_nios2_mul_seq #(
    parameter int MC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] mc_src1,
    output logic [31:0] mc_src2,
    input  logic [31:0] mc_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_CORR = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_XSU = 2'd2;
    localparam logic [1:0] OP_XSS = 2'd3;

    // Latency count at which mc_result is valid for the current pass.
    localparam logic [1:0] LAT_TC = 2'(MC_LATENCY);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [1:0]  r_pass;
    logic [1:0]  r_lat;

    logic        w_accept;
    logic        w_capture;
    logic        w_last_pass;
    logic [63:0] w_addend;
    logic [31:0] w_sub_a;
    logic [31:0] w_sub_b;
    logic [31:0] w_hi_corr;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && !flush;
    assign w_capture   = (r_state == ST_PASS) && (r_lat == LAT_TC);
    assign w_last_pass = (r_op == OP_MUL) || (r_pass == 2'd3);

    // Pass weights: p0 at <<0, p1/p2 (cross terms) at <<16, p3 at <<32.
    always_comb begin
        w_addend = {32'h0, mc_result};
        case (r_pass)
            2'd0:    w_addend = {32'h0, mc_result};
            2'd1,
            2'd2:    w_addend = {16'h0, mc_result, 16'h0};
            default: w_addend = {mc_result, 32'h0};
        endcase
    end

    // Unsigned product -> signed: a negative operand contributed an extra
    // 2^32 * (other operand), which is removed from the upper word.
    assign w_sub_b   = (((r_op == OP_XSS) || (r_op == OP_XSU)) && r_a[31]) ? r_b : 32'h0;
    assign w_sub_a   = ((r_op == OP_XSS) && r_b[31]) ? r_a : 32'h0;
    assign w_hi_corr = r_acc[63:32] - w_sub_b - w_sub_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_result  = 32'h0;
        busy        = 1'b1;
        mc_src1     = 32'h0;
        mc_src2     = 32'h0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                if (r_op == OP_MUL) begin
                    mc_src1 = r_a;
                    mc_src2 = r_b;
                end else begin
                    // pass bit 0 selects the a half, bit 1 the b half
                    mc_src1 = {16'h0, r_pass[0] ? r_a[31:16] : r_a[15:0]};
                    mc_src2 = {16'h0, r_pass[1] ? r_b[31:16] : r_b[15:0]};
                end
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_capture && w_last_pass) begin
                    w_state_nxt = (r_op == OP_MUL) ? ST_RESP : ST_CORR;
                end
            end
            ST_CORR: begin
                w_state_nxt = flush ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_result = (r_op == OP_MUL) ? r_acc[31:0] : r_acc[63:32];
                if (flush || rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= 2'd0;
            r_a    <= 32'h0;
            r_b    <= 32'h0;
            r_acc  <= 64'h0;
            r_pass <= 2'd0;
            r_lat  <= 2'd0;
        end else if (w_accept) begin
            r_op   <= req_op;
            r_a    <= req_a;
            r_b    <= req_b;
            r_acc  <= 64'h0;
            r_pass <= 2'd0;
            r_lat  <= 2'd0;
        end else if ((r_state == ST_PASS) && !flush) begin
            if (w_capture) begin
                r_lat  <= 2'd0;
                r_pass <= r_pass + 2'd1;
                if (r_op == OP_MUL) begin
                    r_acc <= {32'h0, mc_result};
                end else begin
                    r_acc <= r_acc + w_addend;
                end
            end else begin
                r_lat <= r_lat + 2'd1;
            end
        end else if ((r_state == ST_CORR) && !flush) begin
            r_acc[63:32] <= w_hi_corr;
        end
    end

endmodule

// File: tb/tb_nios_system_nios2_mul_seq.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for nios_system_nios2_mul_seq.
// dut1: MC_LATENCY=1 with a single-register cell model.
// dut2: MC_LATENCY=2 with a two-stage cell model.
// Both share every input except req_valid.
// Expected results are hand constants or come from a plain 64-bit
// sign/zero-extended multiply.
// ---------------------------------------------------------------------------
module tb_nios_system_nios2_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid1, req_valid2;
    logic        rsp_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;

    logic        req_ready1, rsp_valid1, busy1;
    logic [31:0] rsp_result1, mc_src1_1, mc_src2_1, mc_result1;
    logic        req_ready2, rsp_valid2, busy2;
    logic [31:0] rsp_result2, mc_src1_2, mc_src2_2, mc_result2;

    logic [31:0] cell1_q, cell2_s1, cell2_s2;

    int          n_err = 0;
    int          n_chk = 0;
    int          lat;
    int          cnt;
    logic [31:0] res;
    logic [63:0] hist [0:15];

    always #5 clk = ~clk;

    nios_system_nios2_mul_seq #(.MC_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
        .mc_src1(mc_src1_1), .mc_src2(mc_src2_1), .mc_result(mc_result1),
        .busy(busy1)
    );

    nios_system_nios2_mul_seq #(.MC_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .mc_src1(mc_src1_2), .mc_src2(mc_src2_2), .mc_result(mc_result2),
        .busy(busy2)
    );

    // multiplier cell models (low 32 bits of the product)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell1_q  <= 32'h0;
            cell2_s1 <= 32'h0;
            cell2_s2 <= 32'h0;
        end else begin
            cell1_q  <= mc_src1_1 * mc_src2_1;
            cell2_s1 <= mc_src1_2 * mc_src2_2;
            cell2_s2 <= cell2_s1;
        end
    end
    assign mc_result1 = cell1_q;
    assign mc_result2 = cell2_s2;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op >= 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'd3) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; the following edge is the accept edge. Afterwards the
    // request fields are scrambled to show they do not affect the op in flight.
    task automatic issue(input bit sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_op = op;
        req_a  = a;
        req_b  = b;
        if (sel) req_valid2 = 1'b1;
        else     req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        req_valid2 = 1'b0;
        req_op     = ~op;
        req_a      = ~a;
        req_b      = b ^ 32'h5A5A_A5A5;
    endtask

    // Count edges from the accept edge until rsp_valid; record cell operands.
    task automatic wait_rsp(input bit sel);
        lat = 0;
        while (!(sel ? rsp_valid2 : rsp_valid1) && lat < 60) begin
            if (lat < 16) hist[lat] = sel ? {mc_src1_2, mc_src2_2} : {mc_src1_1, mc_src2_1};
            tick();
            lat++;
        end
        res = sel ? rsp_result2 : rsp_result1;
    endtask

    task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input string tag);
        rsp_ready = 1'b1;
        issue(sel, op, a, b);
        wait_rsp(sel);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, {32'h0, res}, {32'h0, exp});
        check({tag, "_resp_src"}, sel ? {mc_src1_2, mc_src2_2} : {mc_src1_1, mc_src2_1}, 64'h0);
        check({tag, "_resp_rdy"}, {63'h0, sel ? req_ready2 : req_ready1}, 64'h0);
        tick();
        check({tag, "_done"}, {62'h0, sel ? rsp_valid2 : rsp_valid1,
                               sel ? req_ready2 : req_ready1}, 64'h1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid1 = 1'b0; req_valid2 = 1'b0;
        rsp_ready = 1'b0; req_op = 2'd0; req_a = 32'h0; req_b = 32'h0;
        #12;
        check("rst_ctl",  {61'h0, req_ready1, rsp_valid1, busy1}, 64'h4);
        check("rst_res",  {32'h0, rsp_result1}, 64'h0);
        check("rst_src",  {mc_src1_1, mc_src2_1}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MUL low word, operands passed through whole
        run_op(0, 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 2, "t1_mul");
        check("t1_src_c0", hist[0], {32'h0001_0003, 32'h0002_0005});
        check("t1_src_c1", hist[1], {32'h0001_0003, 32'h0002_0005});

        // MULXUU, four zero-extended half passes
        run_op(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, "t2_xuu_ff");
        for (int k = 0; k < 8; k++) check("t2_src_ff", hist[k], {32'h0000_FFFF, 32'h0000_FFFF});
        run_op(0, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_mul(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), 9, "t2_xuu_mix");
        check("t2_src_p0", hist[0], {32'h0000_5678, 32'h0000_DEF0});
        check("t2_src_p0h", hist[1], {32'h0000_5678, 32'h0000_DEF0});
        check("t2_src_p1", hist[3], {32'h0000_1234, 32'h0000_DEF0});
        check("t2_src_p2", hist[4], {32'h0000_5678, 32'h0000_9ABC});
        check("t2_src_p3", hist[7], {32'h0000_1234, 32'h0000_9ABC});
        run_op(0, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_mul(2'd0, 32'h1234_5678, 32'h9ABC_DEF0), 2, "t2_mul_mix");

        // signed corrections
        run_op(0, 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 9, "t3_xss_m1x2");
        run_op(0, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, "t3_xss_min");
        run_op(0, 2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 9, "t3_xsu");
        run_op(0, 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, "t3_xuu");
        run_op(0, 2'd3, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 9, "t3_xss_bneg");
        run_op(0, 2'd2, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 9, "t3_xsu_bbig");
        run_op(0, 2'd3, 32'h7FFF_FFFF, 32'h8000_0001,
               ref_mul(2'd3, 32'h7FFF_FFFF, 32'h8000_0001), 9, "t3_xss_mix");

        // backpressure with a queued request
        rsp_ready = 1'b0;
        issue(0, 2'd0, 32'h0000_1234, 32'h0000_0010);
        wait_rsp(0);
        check("t4_lat", 64'(lat), 64'd2);
        req_valid1 = 1'b1; req_op = 2'd3; req_a = 32'hFFFF_FFFE; req_b = 32'h0000_0003;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_ctl", {62'h0, rsp_valid1, req_ready1}, 64'h2);
            check("t4_hold_res", {32'h0, rsp_result1}, 64'h0001_2340);
        end
        rsp_ready = 1'b1;
        tick();
        check("t4_idle", {61'h0, rsp_valid1, req_ready1, busy1}, 64'h2);
        tick();
        check("t4_accept", {62'h0, req_ready1, busy1}, 64'h1);
        req_valid1 = 1'b0; req_a = 32'h0; req_b = 32'h0; req_op = 2'd0;
        wait_rsp(0);
        check("t4_q_lat", 64'(lat), 64'd9);
        check("t4_q_res", {32'h0, res}, 64'hFFFF_FFFF);
        tick();

        // flush during p2 of MULXSS
        issue(0, 2'd3, 32'h8765_4321, 32'hCAFE_BABE);
        tick(); tick(); tick(); tick();
        check("t5_p2_src", {mc_src1_1, mc_src2_1}, {32'h0000_4321, 32'h0000_CAFE});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_fl_ctl", {61'h0, busy1, rsp_valid1, req_ready1}, 64'h1);
        check("t5_fl_src", {mc_src1_1, mc_src2_1}, 64'h0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rsp_valid1) cnt++;
        end
        check("t5_fl_norsp", 64'(cnt), 64'd0);

        // flush in IDLE blocks the accept
        req_op = 2'd0; req_a = 32'd2; req_b = 32'd3; req_valid1 = 1'b1; flush = 1'b1;
        tick();
        req_valid1 = 1'b0; flush = 1'b0;
        check("t5_idle_fl", {63'h0, busy1}, 64'h0);

        // flush together with rsp_ready in RESP
        rsp_ready = 1'b0;
        issue(0, 2'd0, 32'd2, 32'd3);
        wait_rsp(0);
        check("t5_rf_res", {32'h0, res}, 64'd6);
        flush = 1'b1; rsp_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_rf_ctl", {62'h0, rsp_valid1, busy1}, 64'h0);

        // asynchronous reset mid-pass
        issue(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("t5_pre_rst", {63'h0, busy1}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_ctl", {61'h0, req_ready1, rsp_valid1, busy1}, 64'h4);
        check("t5_rst_src", {mc_src1_1, mc_src2_1}, 64'h0);
        check("t5_rst_res", {32'h0, rsp_result1}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(0, 2'd0, 32'd7, 32'd6, 32'h0000_002A, 2, "t5_post_rst");

        // MC_LATENCY=2 with a two-stage cell
        run_op(1, 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, "t6_mul");
        run_op(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 13, "t6_xuu");
        run_op(1, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 13, "t6_xss");
        run_op(1, 2'd2, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_mul(2'd2, 32'h1234_5678, 32'h9ABC_DEF0), 13, "t6_xsu");
        check("t6_hold_p0", hist[2], {32'h0000_5678, 32'h0000_DEF0});
        check("t6_p1",      hist[3], {32'h0000_1234, 32'h0000_DEF0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
